conv3x3_sched: RTL and testbench

Sequencer that computes a full 3x3-kernel convolution over a 5x5 8-bit feature map by time-sharing one MAC unit. It latches image and kernel on `start` and feeds the MAC one kernel row (3 pixel/weight pairs) per cycle. It clears the MAC between output points and streams the 9 results out in raster order. It replaces the fully parallel 2D-convolution array where area matters more than throughput.

---
 rtl/conv3x3_sched.sv | 172 +++++++++++++++++
 tb/tb_conv3x3_sched.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_sched.sv
// 3x3 convolution over a latched 5x5 unsigned image, time-sharing one external MAC.
// Feeds one kernel row per cycle and streams the nine results in raster order.
module conv3x3_sched #(
    parameter int OUT_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [199:0]     f,
    input  logic [71:0]      w,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    output logic [1:0]       out_row,
    output logic [1:0]       out_col,
    output logic [OUT_W-1:0] out_data,
    output logic [23:0]      mac_data,
    output logic [23:0]      mac_weight,
    output logic             mac_rst,
    input  logic [OUT_W-1:0] mac_result
);

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        ACC,
        EMIT
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       kr_q, kr_d;
    logic [1:0]       orow_q, orow_d;
    logic [1:0]       ocol_q, ocol_d;
    logic [199:0]     img_q, img_d;
    logic [71:0]      ker_q, ker_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;
    logic [1:0]       out_row_q, out_row_d;
    logic [1:0]       out_col_q, out_col_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;

    logic [2:0]       win_row;
    logic [39:0]      row_bits;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        kr_d        = kr_q;
        orow_d      = orow_q;
        ocol_d      = ocol_q;
        img_d       = img_q;
        ker_d       = ker_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_data_d  = out_data_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    img_d   = f;
                    ker_d   = w;
                    state_d = CLR;
                end
            end
            CLR: begin
                kr_d    = 2'd0;
                orow_d  = 2'd0;
                ocol_d  = 2'd0;
                state_d = ACC;
            end
            ACC: begin
                if (kr_q == 2'd2) begin
                    kr_d    = 2'd0;
                    state_d = EMIT;
                end else begin
                    kr_d = kr_q + 2'd1;
                end
            end
            EMIT: begin
                out_data_d  = mac_result;
                out_row_d   = orow_q;
                out_col_d   = ocol_q;
                out_valid_d = 1'b1;
                if (orow_q == 2'd2 && ocol_q == 2'd2) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = ACC;
                    if (ocol_q == 2'd2) begin
                        ocol_d = 2'd0;
                        orow_d = orow_q + 2'd1;
                    end else begin
                        ocol_d = ocol_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Image row orow+kr as 40 bits, column 0 in the MSBs.
    always_comb begin
        win_row = {1'b0, orow_q} + {1'b0, kr_q};
        case (win_row)
            3'd0:    row_bits = img_q[199:160];
            3'd1:    row_bits = img_q[159:120];
            3'd2:    row_bits = img_q[119:80];
            3'd3:    row_bits = img_q[79:40];
            default: row_bits = img_q[39:0];
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        mac_rst    = 1'b1;
        mac_data   = 24'd0;
        mac_weight = 24'd0;
        if (state_q == ACC) begin
            mac_rst = 1'b0;
            case (ocol_q)
                2'd0:    mac_data = row_bits[39:16];
                2'd1:    mac_data = row_bits[31:8];
                default: mac_data = row_bits[23:0];
            endcase
            case (kr_q)
                2'd0:    mac_weight = ker_q[71:48];
                2'd1:    mac_weight = ker_q[47:24];
                default: mac_weight = ker_q[23:0];
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            kr_q        <= 2'd0;
            orow_q      <= 2'd0;
            ocol_q      <= 2'd0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            out_row_q   <= 2'd0;
            out_col_q   <= 2'd0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            kr_q        <= kr_d;
            orow_q      <= orow_d;
            ocol_q      <= ocol_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_data_q  <= out_data_d;
        end
    end

    // NOTE: the image/kernel store has no reset; it is always loaded on start before anything reads it.
    always_ff @(posedge clk) begin
        img_q <= img_d;
        ker_q <= ker_d;
    end

    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_conv3x3_sched.sv
// Self-checking bench for conv3x3_sched: behavioural MAC, direct-formula convolution
// golden model, and cycle-exact checks of the result stream.
module tb_conv3x3_sched;

    localparam int OUT_W = 20;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [199:0]     f;
    logic [71:0]      w;
    logic             busy, done, out_valid, mac_rst;
    logic [1:0]       out_row, out_col;
    logic [OUT_W-1:0] out_data, mac_result, acc;
    logic [23:0]      mac_data, mac_weight;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    typedef struct {
        int         e;
        logic [1:0] row;
        logic [1:0] col;
        logic [19:0] data;
        logic       dn;
        logic       vld;
    } ev_t;

    ev_t evq[$];
    ev_t mon_ev;

    always #5 clk = ~clk;

    conv3x3_sched #(.OUT_W(OUT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .f          (f),
        .w          (w),
        .busy       (busy),
        .done       (done),
        .out_valid  (out_valid),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_data   (out_data),
        .mac_data   (mac_data),
        .mac_weight (mac_weight),
        .mac_rst    (mac_rst),
        .mac_result (mac_result)
    );

    function automatic int mac_sum(logic [23:0] d, logic [23:0] wt);
        int s = 0;
        for (int j = 0; j < 3; j++)
            s += int'(d[8*(2-j) +: 8]) * int'($signed(wt[8*(2-j) +: 8]));
        return s;
    endfunction

    // MAC contract model
    always @(posedge clk) begin
        if (mac_rst) acc <= '0;
        else         acc <= acc + OUT_W'(mac_sum(mac_data, mac_weight));
    end
    assign mac_result = acc;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        if (out_valid || done) begin
            mon_ev.e    = edge_cnt;
            mon_ev.row  = out_row;
            mon_ev.col  = out_col;
            mon_ev.data = out_data;
            mon_ev.dn   = done;
            mon_ev.vld  = out_valid;
            evq.push_back(mon_ev);
        end
    end

    // Straight definition of the 3x3 convolution, wrapped to 20 bits.
    function automatic logic [19:0] golden(logic [199:0] fv, logic [71:0] wv, int r, int c);
        int s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += int'(fv[8*(24-(5*(r+i)+c+j)) +: 8]) * int'($signed(wv[8*(8-(3*i+j)) +: 8]));
        return 20'(s);
    endfunction

    function automatic logic [199:0] rand_img();
        logic [199:0] v;
        for (int i = 0; i < 25; i++) v[8*i +: 8] = 8'($urandom);
        return v;
    endfunction

    function automatic logic [71:0] rand_ker();
        logic [71:0] v;
        for (int i = 0; i < 9; i++) v[8*i +: 8] = 8'($urandom);
        return v;
    endfunction

    // One full run from a start pulse; optionally zero f/w in cycle 3.
    task automatic run_check(input logic [199:0] fv, input logic [71:0] wv,
                             input bit corrupt, input string tag);
        int n0;
        ev_t ev;
        @(negedge clk);
        f = fv; w = wv; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n0 = edge_cnt;
        start = 1'b0;
        evq.delete();
        for (int n = 1; n <= 38; n++) begin
            checks++;
            if (busy !== (n <= 37)) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b want %b", tag, n, busy, (n <= 37));
            end
            if (n == 1) begin
                checks++;
                if (mac_rst !== 1'b1) begin
                    errors++;
                    $display("FAIL %s mac_rst in CLR: got %b want 1", tag, mac_rst);
                end
            end
            if (n == 2) begin
                checks++;
                if ({mac_rst, mac_data, mac_weight} !== {1'b0, fv[199:176], wv[71:48]}) begin
                    errors++;
                    $display("FAIL %s first ACC mac: got %b/%h/%h want 0/%h/%h", tag,
                             mac_rst, mac_data, mac_weight, fv[199:176], wv[71:48]);
                end
            end
            if (n == 3 && corrupt) begin
                f = '0; w = '0;
            end
            if (n == 38) begin
                checks++;
                if ({mac_rst, mac_data, mac_weight} !== {1'b1, 48'd0}) begin
                    errors++;
                    $display("FAIL %s idle mac: got %b/%h/%h want 1/0/0", tag, mac_rst, mac_data, mac_weight);
                end
            end
            if (n < 38) @(negedge clk);
        end
        @(negedge clk);
        #1;
        checks++;
        if (evq.size() != 9) begin
            errors++;
            $display("FAIL %s pulse count: got %0d want 9", tag, evq.size());
        end
        for (int k = 0; k < 9 && k < evq.size(); k++) begin
            ev = evq[k];
            checks++;
            if (ev.e != n0 + 5 + 4*k || ev.vld !== 1'b1 || ev.dn !== (k == 8)) begin
                errors++;
                $display("FAIL %s pulse %0d timing: got cycle %0d vld %b done %b want cycle %0d vld 1 done %b",
                         tag, k, ev.e - n0 + 1, ev.vld, ev.dn, 6 + 4*k, (k == 8));
            end
            checks++;
            if (ev.row !== 2'(k / 3) || ev.col !== 2'(k % 3)) begin
                errors++;
                $display("FAIL %s pulse %0d coord: got (%0d,%0d) want (%0d,%0d)", tag, k,
                         ev.row, ev.col, k / 3, k % 3);
            end
            checks++;
            if (ev.data !== golden(fv, wv, k / 3, k % 3)) begin
                errors++;
                $display("FAIL %s data (%0d,%0d): got %h want %h", tag, k / 3, k % 3,
                         ev.data, golden(fv, wv, k / 3, k % 3));
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1;
        f = rand_img(); w = rand_ker();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, out_valid, out_row, out_col, out_data, mac_data, mac_weight, mac_rst}
            !== {3'b000, 4'd0, 20'd0, 48'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_hold: got busy %b done %b vld %b row %0d col %0d data %h md %h mw %h mrst %b",
                     busy, done, out_valid, out_row, out_col, out_data, mac_data, mac_weight, mac_rst);
        end
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, out_valid, out_row, out_col, out_data, mac_data, mac_weight, mac_rst}
            !== {3'b000, 4'd0, 20'd0, 48'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_release: got busy %b done %b vld %b data %h mrst %b",
                     busy, done, out_valid, out_data, mac_rst);
        end
    endtask

    task automatic test_all_ones();
        run_check({25{8'h01}}, {9{8'h01}}, 1'b0, "ones");
        for (int k = 0; k < evq.size(); k++) begin
            checks++;
            if (evq[k].data !== 20'd9) begin
                errors++;
                $display("FAIL ones const %0d: got %h want 9", k, evq[k].data);
            end
        end
    endtask

    task automatic test_pattern();
        logic [199:0] fv;
        logic [71:0]  wv;
        fv = {{5{8'd128}}, {4{8'd255, 8'd255, 8'd128, 8'd255, 8'd255}}};
        wv = {{4{8'hFF}}, 8'd8, {4{8'hFF}}};
        run_check(fv, wv, 1'b0, "pattern");
        if (evq.size() == 9) begin
            checks++;
            if (evq[0].data !== 20'h0027B || evq[1].data !== 20'hFFE04 ||
                evq[4].data !== 20'hFFD06 || evq[7].data !== 20'hFFD06) begin
                errors++;
                $display("FAIL pattern spot: got %h %h %h %h want 0027b ffe04 ffd06 ffd06",
                         evq[0].data, evq[1].data, evq[4].data, evq[7].data);
            end
        end
    endtask

    task automatic test_latch();
        run_check(rand_img(), rand_ker(), 1'b1, "latch");
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) run_check(rand_img(), rand_ker(), 1'b0, "random");
    endtask

    task automatic test_start_held();
        logic [199:0] fv;
        logic [71:0]  wv;
        int n0, run, k;
        ev_t ev;
        fv = rand_img(); wv = rand_ker();
        @(negedge clk);
        f = fv; w = wv; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n0 = edge_cnt;
        evq.delete();
        for (int n = 1; n <= 76; n++) begin
            checks++;
            if (busy !== (n != 38 && n <= 75)) begin
                errors++;
                $display("FAIL held busy cycle %0d: got %b want %b", n, busy, (n != 38 && n <= 75));
            end
            if (n == 40) start = 1'b0;
            if (n < 76) @(negedge clk);
        end
        @(negedge clk);
        #1;
        checks++;
        if (evq.size() != 18) begin
            errors++;
            $display("FAIL held pulse count: got %0d want 18", evq.size());
        end
        for (int i = 0; i < 18 && i < evq.size(); i++) begin
            run = i / 9; k = i % 9;
            ev = evq[i];
            checks++;
            if (ev.e != n0 + 38*run + 5 + 4*k || ev.data !== golden(fv, wv, k / 3, k % 3)) begin
                errors++;
                $display("FAIL held run %0d pulse %0d: got cycle %0d data %h want cycle %0d data %h",
                         run, k, ev.e - n0 + 1, ev.data, 38*run + 6 + 4*k, golden(fv, wv, k / 3, k % 3));
            end
        end
    endtask

    task automatic test_reset_mid();
        int n0, late;
        @(negedge clk);
        f = rand_img(); w = rand_ker(); start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n0 = edge_cnt;
        start = 1'b0;
        evq.delete();
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({busy, done, out_valid, out_row, out_col, out_data, mac_data, mac_weight, mac_rst}
            !== {3'b000, 4'd0, 20'd0, 48'd0, 1'b1}) begin
            errors++;
            $display("FAIL abort_state: got busy %b done %b vld %b row %0d col %0d data %h mrst %b",
                     busy, done, out_valid, out_row, out_col, out_data, mac_rst);
        end
        repeat (40) @(negedge clk);
        #1;
        late = 0;
        foreach (evq[i]) if (evq[i].e >= n0 + 20) late++;
        checks++;
        if (late != 0 || evq.size() != 4) begin
            errors++;
            $display("FAIL abort_pulses: got %0d total %0d after reset want 4 total 0 after", evq.size(), late);
        end
        run_check(rand_img(), rand_ker(), 1'b0, "after_abort");
    endtask

    task automatic test_neg128();
        run_check({25{8'hFF}}, {9{8'h80}}, 1'b0, "neg128");
        for (int k = 0; k < evq.size(); k++) begin
            checks++;
            if (evq[k].data !== 20'hB8480) begin
                errors++;
                $display("FAIL neg128 const %0d: got %h want b8480", k, evq[k].data);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; f = '0; w = '0;
        test_reset();
        test_all_ones();
        test_pattern();
        test_latch();
        test_random();
        test_start_held();
        test_reset_mid();
        test_neg128();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
